// File: rtl/ysyx_25040118_lsu.sv
// Load/store unit: one outstanding byte/half/word access over a valid/ready bus,
// with load extension, store byte-lane encoding, error reporting and a bus timeout.
module ysyx_25040118_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         off_q, off_d;
    logic               is_load_q, is_load_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [31:0]        addr_q, addr_d;
    logic               wen_q, wen_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;

    logic               legal_c;
    logic               misaligned_c;
    logic [3:0]         strb_c;
    logic [31:0]        wdata_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;
    logic [31:0]        load_ext_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic               timeout_c;

    // Request decode: funct3 legality, alignment and store lane encoding
    always_comb begin
        legal_c      = 1'b0;
        misaligned_c = 1'b0;
        strb_c       = 4'b1111;
        wdata_c      = in_wdata;
        case (in_funct3)
            3'b000, 3'b001, 3'b010: legal_c = 1'b1;
            3'b100, 3'b101:         legal_c = in_is_load;
            default:                legal_c = 1'b0;
        endcase
        case (in_funct3[1:0])
            2'b00: begin
                strb_c  = 4'b0001 << in_addr[1:0];
                wdata_c = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                misaligned_c = in_addr[0];
                strb_c       = 4'b0011 << in_addr[1:0];
                wdata_c      = {2{in_wdata[15:0]}};
            end
            default: misaligned_c = |in_addr[1:0];
        endcase
    end

    // Response lane selection and extension
    always_comb begin
        case (off_q)
            2'd0:    byte_c = mem_rsp_rdata[7:0];
            2'd1:    byte_c = mem_rsp_rdata[15:8];
            2'd2:    byte_c = mem_rsp_rdata[23:16];
            default: byte_c = mem_rsp_rdata[31:24];
        endcase
        half_c = off_q[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  load_ext_c = {{16{half_c[15]}}, half_c};
            3'b100:  load_ext_c = {24'd0, byte_c};
            3'b101:  load_ext_c = {16'd0, half_c};
            default: load_ext_c = mem_rsp_rdata;
        endcase
    end

    assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout_c = (cnt_inc_c >= CNT_W'(TIMEOUT));

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct3_d  = funct3_q;
        off_d     = off_q;
        is_load_d = is_load_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    funct3_d  = in_funct3;
                    off_d     = in_addr[1:0];
                    is_load_d = in_is_load;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    if (!(in_is_load || in_is_store)) begin
                        state_d = S_DONE;
                    end else if (!legal_c || misaligned_c) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                        addr_d  = {in_addr[31:2], 2'b00};
                        wen_d   = in_is_store;
                        wdata_d = wdata_c;
                        wstrb_d = in_is_store ? strb_c : 4'b0000;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc_c;
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end else if (timeout_c) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc_c;
                if (mem_rsp_valid) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                    rdata_d = is_load_q ? load_ext_c : '0;
                end else if (timeout_c) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            funct3_q  <= '0;
            off_q     <= '0;
            is_load_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            funct3_q  <= funct3_d;
            off_q     <= off_d;
            is_load_q <= is_load_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE) && !rst;
    assign out_valid     = (state_q == S_DONE);
    assign mem_req_valid = (state_q == S_REQ);
    assign out_rdata     = rdata_q;
    assign out_err       = err_q;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;

endmodule

// File: doc/ysyx_25040118_lsu.md
# ysyx_25040118_lsu

Load/store unit placed directly downstream of the execute stage. It takes the effective address and store data computed by the EXU and performs byte, halfword or word accesses over a valid/ready memory bus, using a registered state machine. For loads it returns sign- or zero-extended data to register writeback; for stores it returns a completion. It reports misaligned accesses, illegal funct3 values and bus timeouts as errors, with no side effect on memory.

## Interface
- TIMEOUT, 255: max cycles spent in REQ+WAIT before abort with error; 1..65535.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  EXU offers a request.
- in_ready  out  1  LSU accepts; `(state==IDLE) && !rst`.
- in_is_load  in  1  request is a load.
- in_is_store  in  1  request is a store (never both high).
- in_funct3  in  3  RV32I funct3 of the load/store.
- in_addr  in  32  effective byte address.
- in_wdata  in  32  rs2 value for stores.
- out_valid  out  1  result available.
- out_ready  in  1  writeback consumes the result.
- out_rdata  out  32  extended load data; 0 for stores, errors and non-memory requests.
- out_err  out  1  misaligned, illegal funct3 or timeout.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts the request.
- mem_addr  out  32  word address, `{addr[31:2],2'b00}`.
- mem_wen  out  1  1 = write.
- mem_wdata  out  32  replicated store data.
- mem_wstrb  out  4  byte enables; 0 on reads.
- mem_rsp_valid  in  1  bus response; for both reads and write acks.
- mem_rsp_rdata  in  32  read word.

## Operation
- States:
  - IDLE: in_ready=1.
  - REQ: mem_req_valid=1.
  - WAIT: awaiting mem_rsp_valid.
  - DONE: out_valid=1.
- IDLE, on in_valid, latch all inputs. Then:
  - neither load nor store: go to DONE with rdata=0, err=0.
  - misaligned or illegal funct3: go to DONE with err=1; no bus traffic.
  - otherwise: go to REQ and clear the timeout counter.
- Legal funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- REQ: mem_* are driven from the latched values and held stable until mem_req_ready. On the handshake, go to WAIT.
- WAIT: on mem_rsp_valid, capture data and go to DONE. mem_rsp_valid is ignored outside WAIT.
- Store encoding:
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{b}}.
  - SH: wstrb = 0011<<addr[1:0], wdata = {2{h}}.
  - SW: wstrb = 1111, wdata as is.
- Load extraction:
  - byte = rdata >> (8*addr[1:0]); half = rdata >> (8*addr[1:0]) with addr[1] selecting the half.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word unchanged.
- Timeout counter:
  - 16-bit, saturating; increments every cycle in REQ or WAIT.
  - When counter==TIMEOUT and the state has not advanced, go to DONE with err=1, rdata=0, and drop mem_req_valid.
  - If completion and timeout coincide, completion wins.
- DONE: out_rdata/out_err held stable until out_valid && out_ready, then go to IDLE. The next request can be accepted the cycle after.

## Timing
- Reset (rst high at a clk edge):
  - state=IDLE; out_valid=0, out_rdata=0, out_err=0, mem_req_valid=0, mem_wen=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, counter=0.
  - in_ready=0 while rst is high.
- Reset mid-transaction aborts it with no response. The bus must tolerate a dropped outstanding request.
- All outputs except in_ready are registered-state decodes. No combinational path from mem_* inputs or out_ready to outputs.
- Minimum latency, aligned access, mem_req_ready=1, response one cycle after the handshake:
  - accept at edge 0;
  - REQ during cycle 1;
  - WAIT during cycle 2, with rsp;
  - out_valid during cycle 3.
  - Total: 3 cycles from accept to out_valid.
- Error or non-memory request: out_valid in the cycle after accept.
- Throughput: one request per 4 cycles at best; no pipelining, one outstanding request.

## Test plan
- LB at 0x80000003, rsp_rdata=0x80112233 → out_rdata=0xFFFFFF80, err=0, mem_addr=0x80000000, wstrb=0; out_valid exactly 3 cycles after accept.
- LHU at 0x80000002, rdata=0xBEEF1234 → 0x0000BEEF. LH at 0x80000001 → err=1 next cycle, mem_req_valid never asserted.
- SB at 0x80000001 with wdata=0x000000AB → wstrb=0010, mem_wdata=0xABABABAB, wen=1. SH at 0x80000002, wdata=0x1234 → wstrb=1100, mem_wdata=0x12341234.
- mem_req_ready held low 3 cycles, then rsp for an LW of 0xDEADBEEF → mem_* stable throughout, out_rdata=0xDEADBEEF.
- TIMEOUT=4 with no mem_req_ready → err=1, rdata=0 after 4 counted cycles. Then out_ready low 5 cycles → out_valid/out_rdata/out_err held, in_ready=0.
- rst asserted in WAIT → next cycle IDLE, all outputs 0. A late mem_rsp_valid is ignored, and a fresh LW completes normally.
